// File: rtl/meminf_pkg.sv
// Shared memory-bus types: request/response payloads and arbiter port-ID definitions.
package meminf;

    localparam int unsigned XLEN                 = 32;
    localparam int unsigned MEMBUS_DATA_W        = 32;
    localparam int unsigned MEMBUS_ARB_MAX_PORTS = 8;

    // Wide enough to name any of MEMBUS_ARB_MAX_PORTS requesters
    typedef logic [2:0] MemBusPortId;

    typedef struct packed {
        logic [XLEN-1:0]          addr;
        logic                     wen;
        logic [MEMBUS_DATA_W-1:0] wdata;
    } MemBusReq;

    typedef struct packed {
        logic                     error;
        logic [XLEN-1:0]          addr;
        logic [MEMBUS_DATA_W-1:0] rdata;
    } MemBusResp;

endpackage

// File: rtl/membus_id_fifo.sv
// In-order FIFO of requester IDs for issued-but-unanswered memory requests.
module membus_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    logic [ID_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push_c, do_pop_c;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Qualify push/pop; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        do_push_c = push && !full;
        do_pop_c  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push_c && !do_pop_c)      count_d = count_q + CW'(1);
        else if (!do_push_c && do_pop_c) count_d = count_q - CW'(1);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= push_id;
    end

endmodule

// File: rtl/membus_arbiter.sv
// N-to-1 memory-bus arbiter with request locking and in-order response routing.
// Build option: define MEMBUS_ARB_ROUND_ROBIN_EN for round-robin priority;
// otherwise fixed priority with port 0 highest.
module membus_arbiter
    import meminf::*;
#(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DEPTH     = 4,
    localparam int unsigned CW       = $clog2(DEPTH + 1),
    localparam int unsigned PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic [NUM_PORTS-1:0]                      in_valid,
    output logic [NUM_PORTS-1:0]                      in_ready,
    input  logic [NUM_PORTS-1:0][XLEN-1:0]            in_addr,
    input  logic [NUM_PORTS-1:0]                      in_wen,
    input  logic [NUM_PORTS-1:0][MEMBUS_DATA_W-1:0]   in_wdata,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [XLEN-1:0]                           out_addr,
    output logic                                      out_wen,
    output logic [MEMBUS_DATA_W-1:0]                  out_wdata,
    input  logic                                      out_resp_valid,
    input  logic                                      out_resp_error,
    input  logic [XLEN-1:0]                           out_resp_addr,
    input  logic [MEMBUS_DATA_W-1:0]                  out_resp_rdata,
    output logic [NUM_PORTS-1:0]                      in_resp_valid,
    output logic                                      in_resp_error,
    output logic [XLEN-1:0]                           in_resp_addr,
    output logic [MEMBUS_DATA_W-1:0]                  in_resp_rdata,
    output logic [CW-1:0]                             outstanding,
    output logic                                      spurious_resp
);

    logic [PW-1:0] prio_q, prio_d;
    logic          locked_q, locked_d;
    logic [PW-1:0] lock_port_q, lock_port_d;
    logic          spur_q, spur_d;

    logic [PW-1:0] grant_c;
    logic          found_c;
    logic          fire_c;
    logic          resp_hit_c;
    logic [PW-1:0] head_id;
    logic          fifo_full, fifo_empty;
    MemBusReq      sel_req_c;
    MemBusResp     resp_c;

    // Grant: locked port wins outright, else first valid port from the priority pointer
    always_comb begin
        int unsigned idx;
        grant_c = prio_q;
        found_c = 1'b0;
        idx     = 0;
        if (locked_q) begin
            grant_c = lock_port_q;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                idx = 32'(prio_q) + i;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                if (!found_c && in_valid[PW'(idx)]) begin
                    found_c = 1'b1;
                    grant_c = PW'(idx);
                end
            end
        end
    end

    // Downstream request path; ready is withheld when full so no port sees a phantom handshake
    always_comb begin
        sel_req_c = '{addr: in_addr[grant_c], wen: in_wen[grant_c], wdata: in_wdata[grant_c]};
        out_valid = reset_n && in_valid[grant_c] && !fifo_full;
        fire_c    = out_valid && out_ready;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            in_ready[p] = reset_n && out_ready && !fifo_full && (grant_c == PW'(p));
        end
    end

    assign out_addr  = sel_req_c.addr;
    assign out_wen   = sel_req_c.wen;
    assign out_wdata = sel_req_c.wdata;

    // Upstream response path: route valid to the oldest outstanding ID, broadcast payload
    always_comb begin
        resp_c     = '{error: out_resp_error, addr: out_resp_addr, rdata: out_resp_rdata};
        resp_hit_c = reset_n && out_resp_valid && !fifo_empty;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            in_resp_valid[p] = resp_hit_c && (head_id == PW'(p));
        end
    end

    assign in_resp_error = resp_c.error;
    assign in_resp_addr  = resp_c.addr;
    assign in_resp_rdata = resp_c.rdata;
    assign spurious_resp = spur_q;

    // Lock, priority and sticky-error next state
    always_comb begin
        locked_d    = locked_q;
        lock_port_d = lock_port_q;
        prio_d      = prio_q;
        spur_d      = spur_q || (out_resp_valid && fifo_empty);
        if (fire_c) begin
            locked_d = 1'b0;
`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
            if (grant_c == PW'(NUM_PORTS - 1)) prio_d = '0;
            else                               prio_d = grant_c + PW'(1);
`endif
        end else if (out_valid) begin
            locked_d    = 1'b1;
            lock_port_d = grant_c;
        end else if (locked_q && !in_valid[lock_port_q]) begin
            locked_d = 1'b0;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q      <= '0;
            locked_q    <= 1'b0;
            lock_port_q <= '0;
            spur_q      <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            locked_q    <= locked_d;
            lock_port_q <= lock_port_d;
            spur_q      <= spur_d;
        end
    end

    membus_id_fifo #(
        .DEPTH (DEPTH),
        .ID_W  (PW)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push    (fire_c),
        .push_id (grant_c),
        .pop     (out_resp_valid),
        .head    (head_id),
        .count   (outstanding),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed, table-driven bench for membus_arbiter (2 ports, depth 4).
module tb_membus_arbiter;
    import meminf::*;

    localparam logic [31:0] A0 = 32'h0000_0200;
    localparam logic [31:0] A1 = 32'h0000_0100;
    localparam logic [31:0] W0 = 32'hAAAA_0000;
    localparam logic [31:0] W1 = 32'hBBBB_1111;
    localparam logic [31:0] XX = 32'h0;
    localparam int NV = 30;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [1:0]        in_valid, in_ready, in_wen, in_resp_valid;
    logic [1:0][31:0]  in_addr, in_wdata;
    logic              out_valid, out_ready, out_wen;
    logic [31:0]       out_addr, out_wdata;
    logic              out_resp_valid, out_resp_error, in_resp_error;
    logic [31:0]       out_resp_addr, out_resp_rdata, in_resp_addr, in_resp_rdata;
    logic [2:0]        outstanding;
    logic              spurious_resp;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    membus_arbiter #(.NUM_PORTS(2), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wen(in_wen), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_wen(out_wen), .out_wdata(out_wdata),
        .out_resp_valid(out_resp_valid), .out_resp_error(out_resp_error),
        .out_resp_addr(out_resp_addr), .out_resp_rdata(out_resp_rdata),
        .in_resp_valid(in_resp_valid), .in_resp_error(in_resp_error),
        .in_resp_addr(in_resp_addr), .in_resp_rdata(in_resp_rdata),
        .outstanding(outstanding), .spurious_resp(spurious_resp)
    );

    typedef struct {
        logic [1:0]  v;
        logic        ordy;
        logic        rv;
        logic        eov;
        logic [31:0] eaddr;
        logic        chk_rdy;
        logic [1:0]  erdy;
        logic [1:0]  erv;
        logic [2:0]  eout;
        logic        esp;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic [1:0] v, input logic ordy, input logic rv,
                                input logic eov, input logic [31:0] eaddr, input logic chk_rdy,
                                input logic [1:0] erdy, input logic [1:0] erv,
                                input logic [2:0] eout, input logic esp);
        vec_t r;
        r.v = v; r.ordy = ordy; r.rv = rv; r.eov = eov; r.eaddr = eaddr;
        r.chk_rdy = chk_rdy; r.erdy = erdy; r.erv = erv; r.eout = eout; r.esp = esp;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    initial begin
        logic [1:0] erv;
        logic [1:0] erdy;
        logic [31:0] eaddr;
        int eo;

        // Lock (port 1 held off by out_ready=0, port 0 joins), then port 0 served
        vecs[0]  = mk(2'b00, 1, 0, 0, XX, 0, 2'b00, 2'b00, 3'd0, 0);
        vecs[1]  = mk(2'b10, 0, 0, 1, A1, 1, 2'b00, 2'b00, 3'd0, 0);
        vecs[2]  = mk(2'b11, 0, 0, 1, A1, 1, 2'b00, 2'b00, 3'd0, 0);
        vecs[3]  = mk(2'b11, 0, 0, 1, A1, 1, 2'b00, 2'b00, 3'd0, 0);
        vecs[4]  = mk(2'b11, 1, 0, 1, A1, 1, 2'b10, 2'b00, 3'd0, 0);
        vecs[5]  = mk(2'b11, 1, 0, 1, A0, 1, 2'b01, 2'b00, 3'd1, 0);
        vecs[6]  = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b10, 3'd2, 0);
        vecs[7]  = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b01, 3'd1, 0);
        vecs[8]  = mk(2'b00, 1, 0, 0, XX, 0, 2'b00, 2'b00, 3'd0, 0);
        // Fill to DEPTH, no bypass when full, refill one cycle after a pop, drain
        vecs[9]  = mk(2'b01, 1, 0, 1, A0, 1, 2'b01, 2'b00, 3'd0, 0);
        vecs[10] = mk(2'b01, 1, 0, 1, A0, 1, 2'b01, 2'b00, 3'd1, 0);
        vecs[11] = mk(2'b01, 1, 0, 1, A0, 1, 2'b01, 2'b00, 3'd2, 0);
        vecs[12] = mk(2'b01, 1, 0, 1, A0, 1, 2'b01, 2'b00, 3'd3, 0);
        vecs[13] = mk(2'b01, 1, 0, 0, XX, 0, 2'b00, 2'b00, 3'd4, 0);
        vecs[14] = mk(2'b01, 1, 1, 0, XX, 0, 2'b00, 2'b01, 3'd4, 0);
        vecs[15] = mk(2'b01, 1, 0, 1, A0, 1, 2'b01, 2'b00, 3'd3, 0);
        vecs[16] = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b01, 3'd4, 0);
        vecs[17] = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b01, 3'd3, 0);
        vecs[18] = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b01, 3'd2, 0);
        vecs[19] = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b01, 3'd1, 0);
        vecs[20] = mk(2'b00, 1, 0, 0, XX, 0, 2'b00, 2'b00, 3'd0, 0);
        // Push from port 1 and pop for port 0 in the same cycle
        vecs[21] = mk(2'b01, 1, 0, 1, A0, 1, 2'b01, 2'b00, 3'd0, 0);
        vecs[22] = mk(2'b01, 1, 0, 1, A0, 1, 2'b01, 2'b00, 3'd1, 0);
        vecs[23] = mk(2'b10, 1, 1, 1, A1, 1, 2'b10, 2'b01, 3'd2, 0);
        vecs[24] = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b01, 3'd2, 0);
        vecs[25] = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b10, 3'd1, 0);
        vecs[26] = mk(2'b00, 1, 0, 0, XX, 0, 2'b00, 2'b00, 3'd0, 0);
        // Spurious response with nothing outstanding
        vecs[27] = mk(2'b00, 1, 1, 0, XX, 0, 2'b00, 2'b00, 3'd0, 0);
        vecs[28] = mk(2'b00, 1, 0, 0, XX, 0, 2'b00, 2'b00, 3'd0, 1);
        vecs[29] = mk(2'b00, 1, 0, 0, XX, 0, 2'b00, 2'b00, 3'd0, 1);

        in_addr[0] = A0;  in_addr[1] = A1;
        in_wdata[0] = W0; in_wdata[1] = W1;
        in_wen = 2'b10;
        out_resp_error = 1'b0; out_resp_addr = 32'h0; out_resp_rdata = 32'h0;

        // Reset state with every input active
        reset_n = 1'b0; in_valid = 2'b11; out_ready = 1'b1; out_resp_valid = 1'b1;
        #3;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst in_resp_valid", 32'(in_resp_valid), 32'd0);
        chk("rst outstanding", 32'(outstanding), 32'd0);
        chk("rst spurious", 32'(spurious_resp), 32'd0);
        @(negedge clk);
        in_valid = 2'b00; out_resp_valid = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid = vecs[i].v;
            out_ready = vecs[i].ordy;
            out_resp_valid = vecs[i].rv;
            out_resp_rdata = 32'hD000 + 32'(i);
            out_resp_addr = 32'hA000 + 32'(i);
            out_resp_error = 1'(i % 2);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            if (vecs[i].eov) begin
                chk($sformatf("v%0d out_addr", i), out_addr, vecs[i].eaddr);
                chk($sformatf("v%0d out_wdata", i), out_wdata, (vecs[i].eaddr == A0) ? W0 : W1);
                chk($sformatf("v%0d out_wen", i), 32'(out_wen), (vecs[i].eaddr == A0) ? 32'd0 : 32'd1);
            end
            if (vecs[i].chk_rdy)
                chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].erdy));
            chk($sformatf("v%0d in_resp_valid", i), 32'(in_resp_valid), 32'(vecs[i].erv));
            if (vecs[i].erv != 2'b00) begin
                chk($sformatf("v%0d in_resp_rdata", i), in_resp_rdata, 32'hD000 + 32'(i));
                chk($sformatf("v%0d in_resp_addr", i), in_resp_addr, 32'hA000 + 32'(i));
                chk($sformatf("v%0d in_resp_error", i), 32'(in_resp_error), 32'(i % 2));
            end
            chk($sformatf("v%0d outstanding", i), 32'(outstanding), 32'(vecs[i].eout));
            chk($sformatf("v%0d spurious", i), 32'(spurious_resp), 32'(vecs[i].esp));
        end

        // Reset clears sticky flag
        @(negedge clk);
        in_valid = 2'b00; out_resp_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("pulse spurious cleared", 32'(spurious_resp), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-transaction discards the in-flight ID
        @(negedge clk);
        in_valid = 2'b01; out_ready = 1'b1;
        #1 chk("mid fire", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 2'b00;
        #1 chk("mid outstanding", 32'(outstanding), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("mid rst outstanding", 32'(outstanding), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; out_resp_valid = 1'b1;
        #1 chk("mid late resp dropped", 32'(in_resp_valid), 32'd0);
        @(negedge clk);
        out_resp_valid = 1'b0;
        #1 chk("mid late resp spurious", 32'(spurious_resp), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1 chk("mid spurious cleared", 32'(spurious_resp), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef MEMBUS_ARB_ROUND_ROBIN_EN
        // Both ports streaming, responses two cycles after issue
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = (k < 6) ? 2'b11 : 2'b00;
            out_ready = 1'b1;
            out_resp_valid = (k >= 2);
            out_resp_rdata = 32'hE000 + 32'(k);
            #1;
            if (k < 6) begin
                eaddr = (k % 2 == 0) ? A0 : A1;
                erdy = (k % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("rr%0d out_addr", k), out_addr, eaddr);
                chk($sformatf("rr%0d in_ready", k), 32'(in_ready), 32'(erdy));
            end
            erv = (k < 2) ? 2'b00 : (((k - 2) % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d in_resp_valid", k), 32'(in_resp_valid), 32'(erv));
            if (k >= 2) chk($sformatf("rr%0d rdata", k), in_resp_rdata, 32'hE000 + 32'(k));
            eo = (k == 0) ? 0 : (k == 1) ? 1 : (k == 7) ? 1 : 2;
            chk($sformatf("rr%0d outstanding", k), 32'(outstanding), 32'(eo));
        end
`else
        // Both ports valid: port 0 always wins
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            in_valid = (k < 5) ? 2'b11 : 2'b00;
            out_ready = 1'b1;
            out_resp_valid = (k >= 1);
            out_resp_rdata = 32'hF000 + 32'(k);
            #1;
            if (k < 5) begin
                chk($sformatf("fp%0d out_addr", k), out_addr, A0);
                chk($sformatf("fp%0d in_ready", k), 32'(in_ready), 32'd1);
            end
            erv = (k >= 1) ? 2'b01 : 2'b00;
            chk($sformatf("fp%0d in_resp_valid", k), 32'(in_resp_valid), 32'(erv));
            eo = (k == 0) ? 0 : 1;
            chk($sformatf("fp%0d outstanding", k), 32'(outstanding), 32'(eo));
        end
`endif
        @(negedge clk);
        in_valid = 2'b00; out_resp_valid = 1'b0;
        #1 chk("final outstanding", 32'(outstanding), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, meaning number of upstream requesters (legal range 2..8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning maximum outstanding downstream requests (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  the single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid / in_ready  input / output  NUM_PORTS  per-port request handshake (Chisel-style ready/valid).
REQ-006 SHALL have ports in_addr / in_wen / in_wdata  input  NUM_PORTS x (XLEN / 1 / 32)  per-port request payload.
REQ-007 SHALL have ports out_valid / out_ready / out_addr / out_wen / out_wdata  output / input / output / output / output  1 / 1 / XLEN / 1 / 32  downstream MemBusReq.
REQ-008 SHALL have ports out_resp_valid / out_resp_error / out_resp_addr / out_resp_rdata  input  1 / 1 / XLEN / 32  downstream MemBusResp.
REQ-009 SHALL have ports in_resp_valid  output  NUM_PORTS, and in_resp_error / in_resp_addr / in_resp_rdata  output  1 / XLEN / 32, the upstream response, shared payload.
REQ-010 SHALL have ports outstanding  output  clog2(DEPTH+1)  in-flight count, and spurious_resp  output  1  sticky error flag.

Function
REQ-011 Accept: a request fires when out_valid and out_ready are both 1 in the same cycle. in_ready[g] equals out_ready for the granted port g and 0 for every other port.
REQ-012 out_valid SHALL equal in_valid[g] AND (outstanding < DEPTH). There is no same-cycle bypass when the count is full, even if a response pops in that cycle.
REQ-013 out_addr, out_wen and out_wdata SHALL be combinational copies of port g's payload. Request latency is 0 cycles.
REQ-014 Grant selection when unlocked: the lowest-index valid port at or after the priority pointer, wrapping modulo NUM_PORTS.
REQ-015 Lock: if out_valid=1 and out_ready=0, the block registers locked=1 and lock_port=g. While locked, g = lock_port regardless of other ports' valids.
REQ-016 Lock clears on the handshake of the locked port. If in_valid[lock_port] drops while locked (protocol violation), the lock also clears and the next cycle arbitrates afresh.
REQ-017 Every fired request, read or write, SHALL receive exactly one response. Responses are in order.
REQ-018 On fire, the port index g SHALL be pushed into the ID FIFO. On out_resp_valid, the FIFO head is popped. Push and pop in the same cycle leave the count unchanged.
REQ-019 in_resp_valid[head] SHALL equal out_resp_valid in the same cycle (0-cycle response latency). All other bits of in_resp_valid are 0.
REQ-020 The response payload SHALL be broadcast unmodified to all ports.
REQ-021 If out_resp_valid arrives while the FIFO is empty, the response SHALL be dropped, no in_resp_valid bit is set, and spurious_resp sets and stays at 1 until reset.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH. outstanding equals pushes minus pops, in the range 0..DEPTH.

Reset
REQ-023 reset_n=0 SHALL asynchronously clear outstanding, the FIFO pointers, the priority pointer, locked, lock_port and spurious_resp.
REQ-024 While reset_n=0, out_valid, all in_ready bits and all in_resp_valid bits SHALL be 0.
REQ-025 Assertion of reset mid-transaction SHALL discard in-flight IDs. Responses arriving after reset release with the FIFO empty follow REQ-021.

Configuration
REQ-026 Macro MEMBUS_ARB_ROUND_ROBIN_EN defined: after each fire from port k, the priority pointer becomes (k+1) mod NUM_PORTS.
REQ-027 Macro MEMBUS_ARB_ROUND_ROBIN_EN undefined: the priority pointer is held at 0, giving fixed priority with port 0 highest. Locking (REQ-015) still applies.

Structure
REQ-028 Package meminf SHALL gain: the MemBusPortId typedef (3 bits, enough for 8 ports) and the constant MEMBUS_ARB_MAX_PORTS = 8. MemBusReq and MemBusResp are reused unchanged.
REQ-029 The ID FIFO SHALL be a sub-module, membus_id_fifo, parametrised by DEPTH and ID width, with push, pop, head, count, full and empty.

Verification
REQ-030 NUM_PORTS=2, round-robin on, both ports valid continuously, out_ready=1, responses 2 cycles later -> grants alternate 0,1,0,1 and each port receives its own rdata in issue order.
REQ-031 Port 1 valid with addr=0x100, out_ready=0 for 3 cycles, port 0 becomes valid in cycle 2 -> out_addr stays 0x100 until fire, then port 0 is granted next.
REQ-032 DEPTH=4, 4 fires with no response -> outstanding=4, out_valid=0 despite in_valid=1; one response -> outstanding=3 and the next fire is allowed one cycle later.
REQ-033 Fixed priority (macro undefined), both ports valid for 5 cycles -> port 0 is granted all 5 cycles.
REQ-034 out_resp_valid=1 with outstanding=0 -> no in_resp_valid bit set, spurious_resp=1 held; reset_n pulse -> spurious_resp=0.
REQ-035 Fire from port 1 and response for port 0 in the same cycle with outstanding=2 -> outstanding stays 2, in_resp_valid=2'b01, FIFO head advances.
